// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    StIdle,
    StLocked
  } arb_state_e;

  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefBurstMax = 4;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idw(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-facing bus of the write arbiter.
// master: arbiter side; slave: producers plus FIFO full flag.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned DATA_W  = DefDataW
);
  localparam int unsigned IDW = idw(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_w_en;
  logic [DATA_W-1:0]         fifo_w_data;
  logic [IDW-1:0]            grant_id;
  logic                      busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_w_en, fifo_w_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_w_en, fifo_w_data, grant_id, busy
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % int'(N);
      if (req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// holding each grant for bursts of up to BURST_MAX writes.
// Optional: define FIFO_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned BURST_MAX = DefBurstMax
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef FIFO_ARB_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  fifo_wr_arbiter_if.master  bus
);

  localparam int unsigned IDW = idw(NUM_REQ);
  localparam int unsigned CW  = $clog2(BURST_MAX + 1);

  arb_state_e     state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] owner_q;
  logic [CW-1:0]  cnt_q;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] sel;
  logic           sel_valid;
  logic           xfer;

  function automatic logic [IDW-1:0] wrap_inc(logic [IDW-1:0] x);
    return (int'(x) == int'(NUM_REQ) - 1) ? '0 : x + 1'b1;
  endfunction

  rr_priority_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Zero-latency acceptance: outputs decode state and live inputs; reset blocks any write.
  always_comb begin
    sel             = (state_q == StLocked) ? owner_q : pick_idx;
    sel_valid       = (state_q == StLocked) ? bus.req_valid[owner_q] : pick_any;
    xfer            = rst_n && sel_valid && !bus.fifo_full;
    bus.fifo_w_en   = xfer;
    bus.req_ready   = '0;
    bus.fifo_w_data = '0;
    if (xfer) begin
      bus.req_ready[sel] = 1'b1;
      bus.fifo_w_data    = bus.req_data[32'(sel) * DATA_W +: DATA_W];
    end
    if (state_q == StLocked) begin
      bus.grant_id = owner_q;
    end else begin
      bus.grant_id = (pick_any && rst_n) ? pick_idx : owner_q;
    end
    bus.busy = (state_q == StLocked);
  end

  // Burst FSM: IDLE arbitrates, LOCKED keeps the owner until burst end or withdrawal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            owner_q <= sel;
            if (BURST_MAX == 1) begin
              ptr_q <= wrap_inc(sel);
            end else begin
              cnt_q   <= CW'(1);
              state_q <= StLocked;
            end
          end
        end
        StLocked: begin
          if (!bus.req_valid[owner_q]) begin
            // Withdrawal costs one bubble cycle before re-arbitration.
            state_q <= StIdle;
            ptr_q   <= wrap_inc(owner_q);
            cnt_q   <= '0;
          end else if (xfer) begin
            if (cnt_q == CW'(BURST_MAX - 1)) begin
              state_q <= StIdle;
              ptr_q   <= wrap_inc(owner_q);
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  // Count cycles where some producer waits on a full FIFO; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((|bus.req_valid) && bus.fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
